// File: rtl/player_motion.sv
// Player kinematics: per-tick walk/jump/gravity integration with per-side collision response.
// Define PLAYER_WRAP_X_EN for horizontal wrap-around; otherwise x saturates at the screen edges.
module player_motion #(
    parameter int POS_W      = 10,
    parameter int VEL_W      = 6,
    parameter int X_INIT     = 200,
    parameter int Y_INIT     = 300,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 623,
    parameter int Y_MAX      = 463,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_SPEED = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_SPEED  = 20
) (
    input  logic               sim_clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               jump,
    input  logic [3:0]         player_col,
    output logic [2*POS_W-1:0] player_pos,
    output logic [VEL_W-1:0]   x_vel,
    output logic [VEL_W-1:0]   y_vel,
    output logic               grounded
);

    typedef enum logic {stGround, stAir} stateT;

    localparam int PW = POS_W + 2;

    localparam logic signed [VEL_W:0] MAXV  = (VEL_W+1)'(MAX_SPEED);
    localparam logic signed [VEL_W:0] WALKV = (VEL_W+1)'(WALK_SPEED);
    localparam logic signed [VEL_W:0] JUMPV = (VEL_W+1)'(JUMP_SPEED);
    localparam logic signed [VEL_W:0] GRAVV = (VEL_W+1)'(GRAVITY);

    localparam logic signed [PW-1:0] XMINS = PW'(X_MIN);
    localparam logic signed [PW-1:0] XMAXS = PW'(X_MAX);
    localparam logic signed [PW-1:0] YMAXS = PW'(Y_MAX);
    localparam logic signed [PW-1:0] ONES  = PW'(1);
`ifdef PLAYER_WRAP_X_EN
    localparam logic signed [PW-1:0] XSPAN = PW'(X_MAX - X_MIN + 1);
`endif

    stateT              state, stateNext;
    logic [POS_W-1:0]   xPos, yPos, xPosNext, yPosNext;
    logic [VEL_W-1:0]   xVel, yVel, xVelNext, yVelNext;

    logic signed [VEL_W:0]  xvCand, yvCand;
    logic signed [PW-1:0]   xAdj, xSum, ySum;
    logic                   yHold;

    function automatic logic [VEL_W-1:0] satVel(input logic signed [VEL_W:0] v);
        if (v > MAXV)
            return MAXV[VEL_W-1:0];
        else if (v < -MAXV)
            return VEL_W'(-MAXV);
        else
            return v[VEL_W-1:0];
    endfunction

    function automatic logic signed [PW-1:0] velExt(input logic [VEL_W-1:0] v);
        return {{(PW-VEL_W){v[VEL_W-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] posExt(input logic [POS_W-1:0] p);
        return {2'b00, p};
    endfunction

    always_ff @(posedge sim_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= stAir;
            xPos  <= POS_W'(X_INIT);
            yPos  <= POS_W'(Y_INIT);
            xVel  <= '0;
            yVel  <= '0;
        end else if (tick) begin
            state <= stateNext;
            xPos  <= xPosNext;
            yPos  <= yPosNext;
            xVel  <= xVelNext;
            yVel  <= yVelNext;
        end
    end

    always_comb begin
        stateNext = state;
        xPosNext  = xPos;
        yPosNext  = yPos;
        xVelNext  = xVel;
        yVelNext  = yVel;
        xvCand    = '0;
        yvCand    = '0;
        xAdj      = '0;
        xSum      = '0;
        ySum      = '0;
        yHold     = 1'b0;

        if (player_col == 4'b1111) begin
            // Fully enclosed: kill motion, keep position and state.
            xVelNext = '0;
            yVelNext = '0;
        end else begin
            if (move_right && !move_left)
                xvCand = WALKV;
            else if (move_left && !move_right)
                xvCand = -WALKV;

            xVelNext = satVel(xvCand);
            if (xvCand > 0 && player_col[0]) begin
                xVelNext = '0;
                xAdj     = -ONES;
            end else if (xvCand < 0 && player_col[1]) begin
                xVelNext = '0;
                xAdj     = ONES;
            end

            xSum = posExt(xPos) + velExt(xVelNext) + xAdj;
`ifdef PLAYER_WRAP_X_EN
            if (xSum > XMAXS)
                xPosNext = POS_W'(xSum - XSPAN);
            else if (xSum < XMINS)
                xPosNext = POS_W'(xSum + XSPAN);
            else
                xPosNext = xSum[POS_W-1:0];
`else
            if (xSum > XMAXS) begin
                xPosNext = POS_W'(X_MAX);
                xVelNext = '0;
            end else if (xSum < XMINS) begin
                xPosNext = POS_W'(X_MIN);
                xVelNext = '0;
            end else begin
                xPosNext = xSum[POS_W-1:0];
            end
`endif

            case (state)
                stGround: begin
                    if (jump && !player_col[3]) begin
                        yvCand    = -JUMPV;
                        stateNext = stAir;
                    end else if (!player_col[2]) begin
                        yvCand    = GRAVV;
                        stateNext = stAir;
                    end
                end
                default: begin
                    if (player_col[2] && !yVel[VEL_W-1]) begin
                        stateNext = stGround;
                        yHold     = 1'b1;
                    end else if (!(player_col[3] && yVel[VEL_W-1])) begin
                        yvCand = $signed({yVel[VEL_W-1], yVel}) + GRAVV;
                    end
                end
            endcase

            yVelNext = satVel(yvCand);
            // Landing freezes y for the tick so the sprite does not sink into the floor.
            ySum = yHold ? posExt(yPos) : posExt(yPos) + velExt(yVelNext);
            if (ySum < 0) begin
                yPosNext = '0;
                yVelNext = '0;
            end else if (ySum > YMAXS) begin
                yPosNext = POS_W'(Y_MAX);
                yVelNext = '0;
            end else begin
                yPosNext = ySum[POS_W-1:0];
            end
        end
    end

    assign player_pos = {xPos, yPos};
    assign x_vel      = xVel;
    assign y_vel      = yVel;
    assign grounded   = (state == stGround);

endmodule
